// File: rtl/radix4_ctrl_if.sv
// Host/datapath-facing bundle of the radix-4 Booth sequencer.
// The master drives start and the Booth triplet; the controller returns state.
interface radix4_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic [2:0]       booth_bits;
    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output booth_bits,
        input  state,
        input  count,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  booth_bits,
        output state,
        output count,
        output busy,
        output done
    );
endinterface

// File: rtl/radix4_ctrl.sv
// Sequencing FSM for the radix-4 Booth multiplier datapath.
// Runs N/2 iterations, skipping the accumulate cycle on zero partial products.
module radix4_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    radix4_ctrl_if.slave bus
);
    localparam int               ITER = N / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        INIT  = 3'b001,
        EVAL  = 3'b010,
        ADD   = 3'b011,
        SHIFT = 3'b100,
        DONE  = 3'b101
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st)
                IDLE: begin
                    if (bus.start) begin
                        st     <= INIT;
                        busy_q <= 1'b1;
                    end
                end
                INIT: begin
                    cnt <= '0;
                    st  <= EVAL;
                end
                EVAL: begin
                    // Triplets 000/111 select a zero partial product
                    if (bus.booth_bits == 3'b000 || bus.booth_bits == 3'b111)
                        st <= SHIFT;
                    else
                        st <= ADD;
                end
                ADD: st <= SHIFT;
                SHIFT: begin
                    if (cnt == LAST) begin
                        st     <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        st  <= EVAL;
                    end
                end
                DONE: begin
                    st     <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    st     <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state = st;
    assign bus.count = cnt;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: doc/radix4_ctrl.md
Name: radix4_ctrl

Overview:
Sequencing FSM for the radix-4 Booth multiplier datapath. Drives the 3-bit state code that the datapath's load/select decoder turns into register load enables and mux selects. Counts the N/2 Booth iterations, skips the accumulate cycle for zero partial products, and provides a start/busy/done handshake to the host.

Parameters:
N, 8, operand width in bits; even, >= 4; iterations = N/2.
CNT_W, 3, iteration counter width; must satisfy 2^CNT_W >= N/2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a multiply; sampled only in IDLE.
booth_bits  input  3  current Booth triplet {q[1],q[0],q[-1]} from the multiplier register.
state  output  3  state code to the load/select decoder.
count  output  CNT_W  completed-iteration count.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; product register valid.

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: state=000 (IDLE), count=0, busy=0, done=0. Reset mid-operation aborts immediately with no done pulse.
- All outputs are registered or decoded from registered state only. No combinational path from start or booth_bits to any output.
- State codes:
  - IDLE=000: busy=0. start=1 -> INIT, else stay.
  - INIT=001: operands load, accumulator clears, count<=0. Next: EVAL.
  - EVAL=010: inspect booth_bits. 000 or 111 -> SHIFT (skip add); otherwise -> ADD.
  - ADD=011: accumulator += selected partial product. Next: SHIFT.
  - SHIFT=100: arithmetic shift right by 2. If count==N/2-1 -> DONE, else count<=count+1 and -> EVAL.
  - DONE=101: done=1 for exactly this cycle; count holds N/2-1. Next: IDLE.
  - Codes 110 and 111 are illegal: next state is IDLE, count<=0, and done is not asserted.
- start is ignored in every state except IDLE. start held high continuously makes a new operation begin at the cycle after DONE's IDLE cycle, so there is at least 1 IDLE cycle between operations.
- booth_bits is sampled only in EVAL. It is don't-care in all other states.
- Latency, counted from the rising edge where IDLE samples start=1 (INIT is cycle 1):
  - Per iteration: 3 cycles with ADD, 2 cycles when skipped.
  - done is high in cycle 2 + sum(iteration cycles).
  - N=8: max 14 (no skips), min 10 (all skips).
- busy rises the cycle INIT is entered and falls on entry to IDLE.
- count wraps never; the terminal compare is on N/2-1 exactly.

Test Plan:
- Reset: assert rst mid-ADD (state=011, count=2) -> state=000, count=0, busy=0, done=0 asynchronously, before the next clk edge. On release, remains IDLE with start=0.
- Full-add path, N=8: start pulse, booth_bits=010 every EVAL -> sequence 001, (010,011,100)x4, 101. done high in cycle 14 only; count=3 at DONE; busy high cycles 1-14.
- All-skip path: booth_bits=000 at EVAL 1-2 and 111 at EVAL 3-4 -> no 011 visited; done in cycle 10.
- Mixed: booth_bits 110, 000, 001, 111 -> ADD taken in iterations 0 and 2 only; done in cycle 12.
- Start handling: start toggled high during EVAL/ADD/DONE -> no restart, exactly one done per IDLE-sampled start. start held high for 40 cycles with no skips -> done pulses in cycles 14 and 29, with one IDLE cycle between operations.
- Illegal code: force state register to 110 -> next cycle state=000, count=0, done stays 0.
